reg_write_arbiter: RTL and testbench



---
 rtl/reg_write_arbiter.sv | 115 +++++++++++
 tb/tb_reg_write_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register write port (data + enable channels)
// among n requesters; the winner is held until both channels are consumed.
//
// state    | meaning
// S_IDLE   | no transaction held; the round-robin scan from prio picks a winner
// S_LOCKED | winner lock_q is held until both downstream channels are consumed
module reg_write_arbiter #(
    parameter int width = 1,
    parameter int n     = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [n*width-1:0]   IN_WRITE,
    input  logic [n-1:0]         IN_WRITE_VALID,
    output logic [n-1:0]         IN_WRITE_CONSUMED,
    input  logic [n-1:0]         IN_EN_WRITE,
    output logic [width-1:0]     OUT_WRITE,
    output logic                 OUT_WRITE_VALID,
    input  logic                 OUT_WRITE_CONSUMED,
    output logic                 OUT_EN_WRITE,
    output logic                 OUT_EN_WRITE_VALID,
    input  logic                 OUT_EN_WRITE_CONSUMED,
    output logic [n-1:0]         OUT_GRANT
);

    localparam int IW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   prio_q, prio_d;
    logic [IW-1:0]   lock_q, lock_d;
    logic            data_done_q, data_done_d;
    logic            en_done_q, en_done_d;

    logic            found;
    logic [IW-1:0]   g;
    logic [IW-1:0]   sel;
    logic            active;
    logic            data_ok;
    logic            en_ok;
    int              idx;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            prio_q      <= '0;
            lock_q      <= '0;
            data_done_q <= 1'b0;
            en_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            data_done_q <= data_done_d;
            en_done_q   <= en_done_d;
        end
    end

    // First valid requester scanning prio, prio+1, ... with wrap at n.
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = 0;
        for (int k = 0; k < n; k++) begin
            idx = int'(prio_q) + k;
            if (idx >= n) idx = idx - n;
            if (!found && IN_WRITE_VALID[idx]) begin
                found = 1'b1;
                g     = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        prio_d             = prio_q;
        lock_d             = lock_q;
        data_done_d        = data_done_q;
        en_done_d          = en_done_q;
        IN_WRITE_CONSUMED  = '0;
        OUT_GRANT          = '0;
        OUT_WRITE          = '0;
        OUT_EN_WRITE       = 1'b0;
        OUT_WRITE_VALID    = 1'b0;
        OUT_EN_WRITE_VALID = 1'b0;

        sel     = (state_q == S_LOCKED) ? lock_q : g;
        active  = (state_q == S_LOCKED) || found;
        data_ok = data_done_q || OUT_WRITE_CONSUMED;
        en_ok   = en_done_q || OUT_EN_WRITE_CONSUMED;

        if (RST_N && active) begin
            OUT_GRANT[sel]     = 1'b1;
            OUT_WRITE          = IN_WRITE[int'(sel)*width +: width];
            OUT_EN_WRITE       = IN_EN_WRITE[sel];
            OUT_WRITE_VALID    = !data_done_q;
            OUT_EN_WRITE_VALID = !en_done_q;

            if (data_ok && en_ok) begin
                IN_WRITE_CONSUMED[sel] = 1'b1;
                prio_d      = (int'(sel) == n - 1) ? '0 : sel + IW'(1);
                state_d     = S_IDLE;
                data_done_d = 1'b0;
                en_done_d   = 1'b0;
            end else begin
                state_d     = S_LOCKED;
                lock_d      = sel;
                data_done_d = data_ok;
                en_done_d   = en_ok;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a 4-requester and a 3-requester
// instance, outputs sampled mid-cycle against hand-computed values.
module tb_reg_write_arbiter;

    logic        clk_sys;
    logic        rst_b;

    logic [31:0] a_data;
    logic [3:0]  a_valid, a_en, a_cons, a_grant;
    logic [7:0]  a_wr;
    logic        a_wr_valid, a_en_out, a_en_valid, a_dcons, a_econs;

    logic [23:0] b_data;
    logic [2:0]  b_valid, b_en, b_cons, b_grant;
    logic [7:0]  b_wr;
    logic        b_wr_valid, b_en_out, b_en_valid, b_dcons, b_econs;

    int total = 0;
    int bad   = 0;

    reg_write_arbiter #(.width(8), .n(4)) dut_a (
        .CLK(clk_sys), .RST_N(rst_b),
        .IN_WRITE(a_data), .IN_WRITE_VALID(a_valid), .IN_WRITE_CONSUMED(a_cons),
        .IN_EN_WRITE(a_en),
        .OUT_WRITE(a_wr), .OUT_WRITE_VALID(a_wr_valid), .OUT_WRITE_CONSUMED(a_dcons),
        .OUT_EN_WRITE(a_en_out), .OUT_EN_WRITE_VALID(a_en_valid),
        .OUT_EN_WRITE_CONSUMED(a_econs), .OUT_GRANT(a_grant)
    );

    reg_write_arbiter #(.width(8), .n(3)) dut_b (
        .CLK(clk_sys), .RST_N(rst_b),
        .IN_WRITE(b_data), .IN_WRITE_VALID(b_valid), .IN_WRITE_CONSUMED(b_cons),
        .IN_EN_WRITE(b_en),
        .OUT_WRITE(b_wr), .OUT_WRITE_VALID(b_wr_valid), .OUT_WRITE_CONSUMED(b_dcons),
        .OUT_EN_WRITE(b_en_out), .OUT_EN_WRITE_VALID(b_en_valid),
        .OUT_EN_WRITE_CONSUMED(b_econs), .OUT_GRANT(b_grant)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after posedge; checks happen at the following negedge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        logic [3:0] rr [5];
        rr[0] = 4'b0001; rr[1] = 4'b0010; rr[2] = 4'b0100; rr[3] = 4'b1000; rr[4] = 4'b0001;

        rst_b   = 1'b0;
        a_data  = '0; a_valid = 4'hF; a_en = 4'hF; a_dcons = 1'b1; a_econs = 1'b1;
        b_data  = '0; b_valid = 3'b000; b_en = 3'b111; b_dcons = 1'b1; b_econs = 1'b1;
        #1;

        // reset forces outputs quiet even with requests pending
        settle();
        chk("rst_grant", a_grant, 4'b0000);
        chk("rst_cons", a_cons, 4'b0000);
        chk("rst_wvalid", a_wr_valid, 1'b0);
        chk("rst_envalid", a_en_valid, 1'b0);
        tick();
        tick();

        // single request from requester 2
        rst_b  = 1'b1;
        a_valid = 4'b0100;
        a_en    = 4'b0100;
        a_data  = 32'h00A5_0000;
        settle();
        chk("single_data", a_wr, 8'hA5);
        chk("single_grant", a_grant, 4'b0100);
        chk("single_cons", a_cons, 4'b0100);
        chk("single_wvalid", a_wr_valid, 1'b1);
        chk("single_en", a_en_out, 1'b1);
        tick();

        // prio is now 3: with all valid, requester 3 wins, then 0,1,2,3,0
        a_valid = 4'hF;
        a_en    = 4'hF;
        a_data  = 32'h4433_2211;
        settle();
        chk("prio3_grant", a_grant, 4'b1000);
        chk("prio3_data", a_wr, 8'h44);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("rr_grant%0d", i), a_grant, rr[i]);
            chk($sformatf("rr_cons%0d", i), a_cons, rr[i]);
            tick();
        end

        // back-pressure on requester 1 (prio is 1), requester 0 joins mid-lock
        a_valid = 4'b0010;
        a_data  = 32'h0000_3C00;
        a_dcons = 1'b0;
        a_econs = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("bp_grant%0d", c), a_grant, 4'b0010);
            chk($sformatf("bp_data%0d", c), a_wr, 8'h3C);
            chk($sformatf("bp_cons%0d", c), a_cons, 4'b0000);
            tick();
            a_valid = 4'b0011;
        end
        a_dcons = 1'b1;
        a_econs = 1'b1;
        settle();
        chk("bp_grant3", a_grant, 4'b0010);
        chk("bp_data3", a_wr, 8'h3C);
        chk("bp_cons3", a_cons, 4'b0010);
        tick();

        // prio is 2: requester 2 beats requester 0
        a_valid = 4'b0101;
        settle();
        chk("after_bp_grant", a_grant, 4'b0100);
        tick();
        // prio is 3: only requester 0 valid, scan wraps to it
        a_valid = 4'b0001;
        settle();
        chk("wrap_scan_grant", a_grant, 4'b0001);
        tick();

        // split consume on requester 1: data at cycle 0, enable at cycle 2
        a_valid = 4'b0010;
        a_data  = 32'h0000_5A00;
        a_dcons = 1'b1;
        a_econs = 1'b0;
        settle();
        chk("split0_wvalid", a_wr_valid, 1'b1);
        chk("split0_envalid", a_en_valid, 1'b1);
        chk("split0_cons", a_cons, 4'b0000);
        tick();
        a_dcons = 1'b0;
        settle();
        chk("split1_wvalid", a_wr_valid, 1'b0);
        chk("split1_envalid", a_en_valid, 1'b1);
        chk("split1_data", a_wr, 8'h5A);
        chk("split1_cons", a_cons, 4'b0000);
        tick();
        a_econs = 1'b1;
        settle();
        chk("split2_wvalid", a_wr_valid, 1'b0);
        chk("split2_envalid", a_en_valid, 1'b1);
        chk("split2_cons", a_cons, 4'b0010);
        tick();
        a_valid = 4'b0000;
        settle();
        chk("split3_grant", a_grant, 4'b0000);
        chk("split3_cons", a_cons, 4'b0000);
        tick();

        // reset while locked on requester 2 (prio is 2)
        a_valid = 4'b0100;
        a_dcons = 1'b0;
        a_econs = 1'b0;
        settle();
        chk("lock_grant", a_grant, 4'b0100);
        tick();
        rst_b   = 1'b0;
        a_dcons = 1'b1;
        a_econs = 1'b1;
        settle();
        chk("rstlock_cons", a_cons, 4'b0000);
        chk("rstlock_grant", a_grant, 4'b0000);
        tick();
        rst_b   = 1'b1;
        a_valid = 4'hF;
        a_data  = 32'h4433_2211;
        settle();
        chk("post_rst_grant", a_grant, 4'b0001);
        chk("post_rst_cons", a_cons, 4'b0001);
        tick();
        a_valid = 4'b0000;

        // n=3: null write from requester 2, then prio must wrap to 0
        b_valid = 3'b100;
        b_en    = 3'b011;
        b_data  = 24'h77_0000;
        settle();
        chk("null_grant", b_grant, 3'b100);
        chk("null_en", b_en_out, 1'b0);
        chk("null_envalid", b_en_valid, 1'b1);
        chk("null_data", b_wr, 8'h77);
        chk("null_cons", b_cons, 3'b100);
        tick();
        b_valid = 3'b111;
        settle();
        chk("n3_wrap_grant", b_grant, 3'b001);
        tick();
        settle();
        chk("n3_next_grant", b_grant, 3'b010);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
